rstatus_writeback: RTL and testbench
====================================

Name: rstatus_writeback

Overview:
- Consumer end of the overflow-status interface. Takes per-instruction status events from execute:
  - ALU overflow, with a 2-bit rstatus code: 1 = add, 3 = sub, 2 = addi.
  - setx, with a 27-bit target.
- Keeps the architectural $rstatus shadow and queues the required $r30 writes in a small FIFO.
- Drains the FIFO into the shared register-file write port through a req/ack handshake.
- Provides bex_taken, suppresses the faulting rd write, and stalls the pipe when the queue is full.

Parameters:
- DEPTH, 2, number of pending $r30 write entries (power of 2, >=2).
- RSTATUS_REG, 30, register index driven on wr_addr.

Ports:
- clock  in  1  single design clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ovf_valid  in  1  execute-stage instruction overflowed and its check is enabled.
- ovf_code  in  2  rstatus code for that overflow (1/2/3).
- setx_valid  in  1  execute-stage instruction is setx.
- setx_target  in  27  setx immediate.
- wr_req  out  1  head entry is valid and requests the regfile port.
- wr_ack  in  1  regfile port granted this cycle.
- wr_addr  out  5  always RSTATUS_REG.
- wr_data  out  32  head entry data.
- rstatus_q  out  32  architectural rstatus, including queued writes.
- bex_taken  out  1  rstatus_q != 0 (combinational).
- suppress_rd  out  1  equals ovf_valid (combinational); blocks the faulting rd write.
- stall  out  1  FIFO count == DEPTH.
- ovf_lost  out  1  sticky flag: an event was dropped.

Behaviour:
- Reset (asynchronous, when reset_n = 0):
  - FIFO empty; count = 0.
  - rstatus_q = 0, wr_req = 0, wr_data = 0, stall = 0, ovf_lost = 0.
  - Any pending writes are discarded. Reset is level-sensitive and overrides everything.
- Event selection each cycle:
  - If ovf_valid = 1: entry = {30'b0, ovf_code}.
  - Else if setx_valid = 1: entry = {5'b0, setx_target}.
  - If ovf_valid and setx_valid are both 1: ovf wins and setx is discarded without setting ovf_lost.
  - Codes outside 1..3 are stored unchanged.
- Push occurs when an event is present and either count < DEPTH or a pop happens in the same cycle.
  - On push, rstatus_q takes the entry data on the same edge (one-cycle latency from event to rstatus_q/bex_taken).
  - The FIFO stores the entry at the tail.
- Pop occurs when wr_req & wr_ack.
  - The head pointer advances; count decrements unless a push happens in the same cycle.
  - wr_data and wr_req are registered from the FIFO head and reflect the new head on the next cycle.
- wr_req stays high with stable wr_data until acked. No retraction.
- Full:
  - stall = 1 while count == DEPTH.
  - An event arriving with count == DEPTH and no pop that cycle is dropped. rstatus_q is unchanged and ovf_lost is set to 1 and held until reset.
  - Push and pop together while full: accepted; count stays at DEPTH.
- Empty:
  - wr_req = 0; wr_ack is ignored.
  - Push and pop together while empty: impossible, because a pop requires wr_req.
- Pointers wrap modulo DEPTH. Count is clog2(DEPTH)+1 bits.
- FIFO drain order equals event order. The final $r30 value therefore equals rstatus_q once the FIFO is empty.
- State machine per entry slot: EMPTY -> (push) VALID -> (ack at head) EMPTY.

Optional Feature:
- Macro: RSTATUS_STICKY_EN.
- When defined:
  - An overflow event is accepted only if rstatus_q == 0, so the first fault wins.
  - An overflow while rstatus_q != 0 is discarded: no push, ovf_lost unchanged, suppress_rd still 1.
  - setx always overwrites, including a write of 0.
- When undefined: the last accepted event wins.

Test Plan:
- Reset with reset_n = 0 mid-queue (count = 2) -> count = 0, wr_req = 0, rstatus_q = 0 immediately, without waiting for a clock edge.
- ovf_valid = 1, ovf_code = 3, wr_ack held at 0 for 3 cycles then 1 -> rstatus_q = 3 and bex_taken = 1 after one edge; wr_req = 1 with wr_data = 32'h3 and wr_addr = 30 stable until the ack cycle; then wr_req = 0.
- ovf(code 1), then setx(target 27'h12345), then ovf(code 2) on consecutive cycles with wr_ack = 0 and DEPTH = 2:
  - stall = 1 after the 2nd event.
  - The 3rd event is dropped: ovf_lost = 1, rstatus_q = 32'h12345.
  - With wr_ack = 1, the drain order is 1 then 32'h12345.
- Full queue with event and wr_ack together -> event accepted, count stays 2, ovf_lost = 0.
- ovf_valid and setx_valid together (code 2, target 5) -> a single entry 32'h2; suppress_rd = 1 in that cycle.
- With RSTATUS_STICKY_EN: ovf(code 1), then ovf(code 3) -> rstatus_q stays 1 and only one push occurs; a following setx of 0 -> rstatus_q = 0 and bex_taken = 0.

Source files
------------

// File: rtl/rstatus_writeback.sv
// rstatus_writeback: architectural $rstatus shadow plus a DEPTH-entry queue of pending $r30 writes.
// Latency: an accepted event reaches rstatus_q/bex_taken after one edge; the queue head drives wr_req/wr_data one edge after it changes.
// Backpressure: stall is high while the queue is full; an event that arrives while full with no pop is dropped and sets sticky ovf_lost.
// Optional: define RSTATUS_STICKY_EN so that the first overflow wins (an overflow is accepted only while rstatus_q == 0).
module rstatus_writeback #(
  parameter int DEPTH       = 2,
  parameter int RSTATUS_REG = 30
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ovf_valid,
  input  logic [1:0]  ovf_code,
  input  logic        setx_valid,
  input  logic [26:0] setx_target,
  output logic        wr_req,
  input  logic        wr_ack,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] rstatus_q,
  output logic        bex_taken,
  output logic        suppress_rd,
  output logic        stall,
  output logic        ovf_lost
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   rstatus_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          wr_req_q, wr_req_d;
  logic          ovf_lost_q, ovf_lost_d;

  logic          ev_vld;
  logic [31:0]   ev_dat;
  logic          full;
  logic          push;
  logic          pop;

  // Pick this cycle's event: overflow beats setx; a setx that loses is discarded silently.
  always_comb begin
    ev_vld = 1'b0;
    ev_dat = 32'd0;
    if (ovf_valid) begin
`ifdef RSTATUS_STICKY_EN
      // First fault wins: a later overflow is ignored until rstatus is cleared.
      ev_vld = (rstatus_q == 32'd0);
`else
      ev_vld = 1'b1;
`endif
      ev_dat = {30'd0, ovf_code};
    end else if (setx_valid) begin
      ev_vld = 1'b1;
      ev_dat = {5'd0, setx_target};
    end
  end

  assign full = (count_q == CW'(DEPTH));
  assign pop  = wr_req_q & wr_ack;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push = ev_vld & (~full | pop);

  // Next-state for pointers, count, shadow, sticky flag and the registered head view.
  always_comb begin
    head_d     = pop  ? head_q + PW'(1) : head_q;
    tail_d     = push ? tail_q + PW'(1) : tail_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    rstatus_d  = push ? ev_dat : rstatus_q;
    ovf_lost_d = ovf_lost_q | (ev_vld & ~push);
    wr_req_d   = (count_d != '0);
    wr_data_d  = 32'd0;
    if (count_d != '0) begin
      // The new head is the entry being written only when it lands in the head slot.
      if (push && (tail_q == head_d)) begin
        wr_data_d = ev_dat;
      end else begin
        wr_data_d = mem_q[head_d];
      end
    end
  end

  // State registers; reset discards every pending write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rstatus_q  <= 32'd0;
      wr_req_q   <= 1'b0;
      wr_data_q  <= 32'd0;
      ovf_lost_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rstatus_q  <= rstatus_d;
      wr_req_q   <= wr_req_d;
      wr_data_q  <= wr_data_d;
      ovf_lost_q <= ovf_lost_d;
    end
  end

  // Queue storage written at the tail on push.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (push) begin
      mem_q[tail_q] <= ev_dat;
    end
  end

  assign wr_req      = wr_req_q;
  assign wr_data     = wr_data_q;
  assign wr_addr     = 5'(RSTATUS_REG);
  assign bex_taken   = (rstatus_q != 32'd0);
  assign suppress_rd = ovf_valid;
  assign stall       = full;
  assign ovf_lost    = ovf_lost_q;

endmodule

// File: tb/tb_rstatus_writeback.sv
// Testbench for rstatus_writeback: directed vector table, asynchronous reset check,
// and randomized traffic compared against a queue-based reference model.
module tb_rstatus_writeback;

  localparam int DEPTH = 2;

  logic        clock;
  logic        reset_n;
  logic        ovf_valid;
  logic [1:0]  ovf_code;
  logic        setx_valid;
  logic [26:0] setx_target;
  logic        wr_req;
  logic        wr_ack;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rstatus_q;
  logic        bex_taken;
  logic        suppress_rd;
  logic        stall;
  logic        ovf_lost;

  rstatus_writeback #(.DEPTH(DEPTH), .RSTATUS_REG(30)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ovf_valid   (ovf_valid),
    .ovf_code    (ovf_code),
    .setx_valid  (setx_valid),
    .setx_target (setx_target),
    .wr_req      (wr_req),
    .wr_ack      (wr_ack),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rstatus_q   (rstatus_q),
    .bex_taken   (bex_taken),
    .suppress_rd (suppress_rd),
    .stall       (stall),
    .ovf_lost    (ovf_lost)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: pending writes as a plain queue, shadow value and lost flag.
  int unsigned mq[$];
  int unsigned m_rs;
  bit          m_lost;

  typedef struct {
    bit          rst;
    bit          ov;
    bit [1:0]    code;
    bit          sx;
    bit [26:0]   tgt;
    bit          ack;
    bit          req;
    bit [31:0]   data;
    bit [31:0]   rs;
    bit          stl;
    bit          lost;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit ov, bit [1:0] code, bit sx, bit [26:0] tgt, bit ack,
                              bit req, bit [31:0] data, bit [31:0] rs, bit stl, bit lost);
    vec_t v;
    v.rst = rst; v.ov = ov; v.code = code; v.sx = sx; v.tgt = tgt; v.ack = ack;
    v.req = req; v.data = data; v.rs = rs; v.stl = stl; v.lost = lost;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit ov, input bit [1:0] code, input bit sx,
                            input bit [26:0] tgt, input bit ack);
    bit          pop;
    bit          ev;
    bit          space;
    int unsigned val;
    pop = (mq.size() > 0) && ack;
    ev  = 1'b0;
    val = 0;
    if (ov) begin
`ifdef RSTATUS_STICKY_EN
      ev = (m_rs == 0);
`else
      ev = 1'b1;
`endif
      val = int'(code);
    end else if (sx) begin
      ev  = 1'b1;
      val = int'(tgt);
    end
    space = (mq.size() < DEPTH) || pop;
    if (pop) void'(mq.pop_front());
    if (ev) begin
      if (space) begin
        mq.push_back(val);
        m_rs = val;
      end else begin
        m_lost = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".wr_req"},    {31'd0, wr_req},    (mq.size() > 0) ? 32'd1 : 32'd0);
    chk({tag, ".wr_data"},   wr_data,            (mq.size() > 0) ? mq[0] : 32'd0);
    chk({tag, ".wr_addr"},   {27'd0, wr_addr},   32'd30);
    chk({tag, ".rstatus"},   rstatus_q,          m_rs);
    chk({tag, ".bex_taken"}, {31'd0, bex_taken}, (m_rs != 0) ? 32'd1 : 32'd0);
    chk({tag, ".stall"},     {31'd0, stall},     (mq.size() == DEPTH) ? 32'd1 : 32'd0);
    chk({tag, ".ovf_lost"},  {31'd0, ovf_lost},  {31'd0, m_lost});
  endtask

  // Drive one cycle of inputs (called just after a rising edge), advance one edge, compare.
  task automatic cycle(input string tag, input bit ov, input bit [1:0] code, input bit sx,
                       input bit [26:0] tgt, input bit ack);
    ovf_valid   = ov;
    ovf_code    = code;
    setx_valid  = sx;
    setx_target = tgt;
    wr_ack      = ack;
    #1;
    chk({tag, ".suppress_rd"}, {31'd0, suppress_rd}, {31'd0, ov});
    model_step(ov, code, sx, tgt, ack);
    @(posedge clock);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    ovf_valid   = 1'b0;
    ovf_code    = 2'd0;
    setx_valid  = 1'b0;
    setx_target = 27'd0;
    wr_ack      = 1'b0;
    reset_n     = 1'b0;
    mq.delete();
    m_rs   = 0;
    m_lost = 1'b0;
    #3;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_model("reset");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit [31:0] r;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    do_reset();

`ifndef RSTATUS_STICKY_EN
    // rst ov code sx tgt ack | req data rs stall lost
    tbl.push_back(mk(1, 1, 3, 0, 0,        0, 1, 32'h3,     32'h3,     0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 1, 32'h3,     32'h3,     0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 1, 32'h3,     32'h3,     0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 0, 32'h0,     32'h3,     0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 0, 32'h0,     32'h3,     0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0,        0, 1, 32'h1,     32'h1,     0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 27'h12345, 0, 1, 32'h1,     32'h12345, 1, 0));
    tbl.push_back(mk(0, 1, 2, 0, 0,        0, 1, 32'h1,     32'h12345, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 1, 32'h12345, 32'h12345, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 0, 32'h0,     32'h12345, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0,        0, 1, 32'h1,     32'h1,     0, 0));
    tbl.push_back(mk(0, 1, 2, 0, 0,        0, 1, 32'h1,     32'h2,     1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 27'h7,    1, 1, 32'h2,     32'h7,     1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 1, 32'h7,     32'h7,     0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 0, 32'h0,     32'h7,     0, 0));
    tbl.push_back(mk(1, 1, 2, 1, 27'h5,    0, 1, 32'h2,     32'h2,     0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 0, 32'h0,     32'h2,     0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,        0, 1, 32'h0,     32'h0,     0, 0));
`else
    tbl.push_back(mk(1, 1, 1, 0, 0,        0, 1, 32'h1,     32'h1,     0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0,        0, 1, 32'h1,     32'h1,     0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 27'h0,    0, 1, 32'h1,     32'h0,     1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 1, 32'h0,     32'h0,     0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 0, 32'h0,     32'h0,     0, 0));
    tbl.push_back(mk(0, 1, 2, 1, 27'h5,    0, 1, 32'h2,     32'h2,     0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0,        0, 1, 32'h2,     32'h2,     0, 0));
`endif

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      cycle($sformatf("vec%0d", i), tbl[i].ov, tbl[i].code, tbl[i].sx, tbl[i].tgt, tbl[i].ack);
      chk($sformatf("vec%0d.tbl_req", i),   {31'd0, wr_req},  {31'd0, tbl[i].req});
      chk($sformatf("vec%0d.tbl_data", i),  wr_data,          tbl[i].data);
      chk($sformatf("vec%0d.tbl_rs", i),    rstatus_q,        tbl[i].rs);
      chk($sformatf("vec%0d.tbl_stall", i), {31'd0, stall},   {31'd0, tbl[i].stl});
      chk($sformatf("vec%0d.tbl_lost", i),  {31'd0, ovf_lost}, {31'd0, tbl[i].lost});
    end

    // Asynchronous reset while two writes are pending: outputs clear before any edge.
    do_reset();
    cycle("fill0", 1'b1, 2'd1, 1'b0, 27'd0, 1'b0);
    cycle("fill1", 1'b0, 2'd0, 1'b1, 27'h9, 1'b0);
    chk("prereset.stall", {31'd0, stall}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async.wr_req",  {31'd0, wr_req},   32'd0);
    chk("async.rstatus", rstatus_q,         32'd0);
    chk("async.bex",     {31'd0, bex_taken}, 32'd0);
    chk("async.stall",   {31'd0, stall},    32'd0);
    chk("async.wr_data", wr_data,           32'd0);
    @(posedge clock);
    #1;
    do_reset();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      bit          ov;
      bit          sx;
      bit          ack;
      bit [1:0]    code;
      bit [26:0]   tgt;
      ov   = ($urandom_range(0, 9) < 3);
      sx   = ($urandom_range(0, 9) < 3);
      ack  = ($urandom_range(0, 1) == 1);
      r    = $urandom;
      code = r[1:0];
      r    = $urandom;
      tgt  = ($urandom_range(0, 3) == 0) ? 27'd0 : r[26:0];
      cycle($sformatf("rnd%0d", n), ov, code, sx, tgt, ack);
      if (n == 300) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
